// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package sub_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int N_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } state_e;

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generation for one bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: D = A - B computed LSB-first, one bit per clock,
// with a start/busy/done handshake and a single full-subtractor cell.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] D,
    output logic         borrow_out,
    output logic         busy,
    output logic         done
);

    localparam int            CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e        state_r;
    logic [N-1:0]  sa_r;
    logic [N-1:0]  sb_r;
    logic [N-1:0]  res_r;
    logic          br_r;
    logic [CW-1:0] cnt_r;
    logic          diff_s;
    logic          bout_s;
    logic [N-1:0]  res_next_s;

    full_subtractor u_fs (
        .a    (sa_r[0]),
        .b    (sb_r[0]),
        .bin  (br_r),
        .d    (diff_s),
        .bout (bout_s)
    );

    // Result register after this bit: new difference bit enters at the MSB.
    always_comb begin
        res_next_s = {diff_s, res_r[N-1:1]};
    end

    // Handshake FSM, operand/result shift registers, borrow FF and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            sa_r       <= {N{1'b0}};
            sb_r       <= {N{1'b0}};
            res_r      <= {N{1'b0}};
            br_r       <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            D          <= {N{1'b0}};
            borrow_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa_r    <= A;
                        sb_r    <= B;
                        res_r   <= {N{1'b0}};
                        br_r    <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
                        busy    <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    sa_r  <= {1'b0, sa_r[N-1:1]};
                    sb_r  <= {1'b0, sb_r[N-1:1]};
                    res_r <= res_next_s;
                    br_r  <= bout_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    // D and borrow_out only change here, so they hold between results.
                    if (cnt_r == CNT_LAST) begin
                        D          <= res_next_s;
                        borrow_out <= bout_s;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        state_r    <= ST_SHIFT;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed and random bench for serial_subtractor with a queue-based result scoreboard.
module tb_serial_subtractor;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] d;
        logic         b;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] D;
    logic         borrow_out;
    logic         busy;
    logic         done;

    int   vectors    = 0;
    int   miscompares = 0;
    int   done_cnt   = 0;
    int   cyc        = 0;
    exp_t exp_q[$];

    serial_subtractor #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .A          (A),
        .B          (B),
        .D          (D),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t   e;
        int     diff;
        diff = a - b;
        e.d  = N'(diff & ((1 << N) - 1));
        e.b  = (a < b) ? 1'b1 : 1'b0;
        return e;
    endfunction

    // Scoreboard: every done pulse pops and checks the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("D", 32'(D), 32'(e.d));
                chk("borrow_out", 32'(borrow_out), 32'(e.b));
            end
        end
    end

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_timeout", 32'(ok), 32'd1);
    endtask

    // One full operation with exact busy/done timing checks.
    task automatic do_op(input int a, input int b);
        @(negedge clk);
        A     = N'(a);
        B     = N'(b);
        start = 1'b1;
        exp_q.push_back(model(a, b));
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_accept", 32'(busy), 32'd1);
        for (int i = 1; i <= N; i++) begin
            @(posedge clk);
            #1;
            if (i < N) begin
                chk("busy_shift", 32'(busy), 32'd1);
                chk("done_early", 32'(done), 32'd0);
            end else begin
                chk("done_latency", 32'(done), 32'd1);
                chk("busy_end", 32'(busy), 32'd0);
            end
        end
        @(posedge clk);
        #1 chk("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        bit ok;
        int c1;
        int dc;

        rst_n = 1'b0;
        start = 1'b0;
        A     = {N{1'b0}};
        B     = {N{1'b0}};
        #1;
        chk("rst_D", 32'(D), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed values, including borrow and boundary operands.
        do_op(9, 3);
        do_op(3, 9);
        do_op(0, 15);
        do_op(15, 15);
        do_op(15, 0);

        // Start while busy is ignored; A/B changes mid-operation have no effect.
        dc = done_cnt;
        @(negedge clk);
        A = 4'd9; B = 4'd3; start = 1'b1;
        exp_q.push_back(model(9, 3));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        A = 4'd1; B = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        repeat (6) @(negedge clk);
        chk("single_done", 32'(done_cnt - dc), 32'd1);

        // Back-to-back: start held through DONE accepts the next operation.
        @(negedge clk);
        A = 4'd5; B = 4'd2; start = 1'b1;
        exp_q.push_back(model(5, 2));
        @(negedge clk);
        A = 4'd7; B = 4'd1;
        exp_q.push_back(model(7, 1));
        wait_done(ok);
        c1 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(ok);
        chk("b2b_spacing", 32'(cyc - c1), 32'(N + 1));
        repeat (2) @(negedge clk);

        // Asynchronous reset two cycles into SHIFT aborts with no done pulse.
        dc = done_cnt;
        @(negedge clk);
        A = 4'd9; B = 4'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_D", 32'(D), 32'd0);
        chk("arst_borrow", 32'(borrow_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 3) @(negedge clk);
        chk("no_done_after_reset", 32'(done_cnt - dc), 32'd0);
        do_op(5, 2);

        // Random operands.
        for (int i = 0; i < 20; i++) begin
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; the inverse-direction companion to the team's N-bit adder.
- Computes D = A − B LSB-first, one bit per clock, using a single full-subtractor cell and a borrow flip-flop.
- Uses a start/busy/done handshake.
- Sits in the lab datapath where area matters more than latency. Results are checked against the adder by the shared self-checking bench (A − B + B == A).

Parameters:
- N, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- A  input  N  minuend; sampled on the accepting edge only
- B  input  N  subtrahend; sampled on the accepting edge only
- D  output  N  difference, (A − B) mod 2^N
- borrow_out  output  1  final borrow; 1 iff A < B unsigned
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when D and borrow_out become valid

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: rst_n low forces, immediately and independent of clk: state=IDLE, D=0, borrow_out=0, busy=0, done=0, internal shift registers=0, borrow FF=0, bit counter=0.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and the outputs above apply.
- States:
  - IDLE: waiting.
  - SHIFT: N bit-cycles of processing.
  - DONE: one cycle; done=1.
- Accept: on the rising edge where state is IDLE or DONE and start=1:
  - load A into shift register sa and B into sb;
  - clear the borrow FF and the counter;
  - go to SHIFT; busy=1 from that edge.
- SHIFT, each edge:
  - diff = sa[0] ^ sb[0] ^ br
  - br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)
  - the result shift register shifts right with diff entering at MSB; sa and sb shift right; counter increments.
- SHIFT exit: on the edge where counter reaches N−1, i.e. the Nth SHIFT edge:
  - load the result into D and the final borrow into borrow_out;
  - go to DONE; busy=0, done=1.
- Latency: with start accepted at edge k, busy is high from edge k to edge k+N, and done is high for exactly the cycle after edge k+N.
- DONE: the next edge goes to IDLE (done=0). If start=1 on that edge, a new operation is accepted instead (back-to-back; done stays a single-cycle pulse).
- Output hold: D and borrow_out are held stable from DONE until the next DONE. They are not updated during SHIFT.
- start=1 while in SHIFT is ignored, and A/B changes during SHIFT have no effect.
- Width rules: unsigned arithmetic throughout, no sign extension. The borrow FF is 1 bit and the counter is clog2(N) bits.
- Boundary values:
  - A==B gives D=0, borrow_out=0.
  - A=0, B=2^N−1 gives D=1, borrow_out=1.

Decomposition:
- Shared package (sub_pkg) holds:
  - the state encoding localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
  - the default width constant N_DEF=4.
- One natural sub-module: full_subtractor, purely combinational with inputs a, b, bin and outputs d, bout. It is instantiated once inside serial_subtractor.
- Counter, FSM and shift registers stay in the top module.

Test Plan:
- Basic case, N=4: A=9, B=3, one-cycle start → done high exactly 4 cycles after the accepting edge; D=6, borrow_out=0; busy high for 4 cycles.
- Borrow case: A=3, B=9 → D=10 (4'hA), borrow_out=1. A=0, B=15 → D=1, borrow_out=1.
- Equal and extreme operands: A=B=15 → D=0, borrow_out=0. A=15, B=0 → D=15, borrow_out=0.
- Ignore start while busy: pulse start with A=9, B=3, then assert start again 2 cycles later with A=1, B=1 → single done, D=6. Back-to-back start held high through DONE → second result follows N+1 cycles after the first done.
- Reset mid-operation: drop rst_n 2 cycles into SHIFT → D=0, busy=0, done=0 asynchronously; no done pulse afterwards. After release, a new start with A=5, B=2 → D=3.
- Random check: 20 iterations of $random A and B, each waiting for done → D==(A−B)&4'hF and borrow_out==(A<B). On mismatch, display an error and $stop; otherwise display "Passed".
